// File: rtl/io_cmd_sequencer_if.sv
// Host / IO-unit / response signal bundle for io_cmd_sequencer.
// The slave modport is the sequencer's view. The master modport is everything around it:
// the host, the IO unit and the response consumer.
interface io_cmd_sequencer_if #(
    parameter int unsigned INSTRUCTION_SIZE = 3,
    parameter int unsigned SIZE_WORD        = 5,
    parameter int unsigned AUXILIAR_SIZE    = 44,
    parameter int unsigned IO_OUTPUT_SIZE   = 8
);
    // Host command push
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [INSTRUCTION_SIZE-1:0] cmd_instr;
    logic [SIZE_WORD-1:0]        cmd_reg;
    logic [AUXILIAR_SIZE-1:0]    cmd_aux;

    // IO execution unit
    logic [INSTRUCTION_SIZE-1:0] io_instr;
    logic [SIZE_WORD-1:0]        io_reg;
    logic [AUXILIAR_SIZE-1:0]    io_aux;
    logic                        io_valid;
    logic                        io_busy;
    logic                        io_valid_io;
    logic [IO_OUTPUT_SIZE-1:0]   io_result;

    // Read response
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [IO_OUTPUT_SIZE-1:0]   rsp_data;
    logic [SIZE_WORD-1:0]        rsp_reg;

    modport slave (
        input  cmd_valid, cmd_instr, cmd_reg, cmd_aux,
        input  io_busy, io_valid_io, io_result,
        input  rsp_ready,
        output cmd_ready,
        output io_instr, io_reg, io_aux, io_valid,
        output rsp_valid, rsp_data, rsp_reg
    );

    modport master (
        output cmd_valid, cmd_instr, cmd_reg, cmd_aux,
        output io_busy, io_valid_io, io_result,
        output rsp_ready,
        input  cmd_ready,
        input  io_instr, io_reg, io_aux, io_valid,
        input  rsp_valid, rsp_data, rsp_reg
    );
endinterface

// File: rtl/io_cmd_sequencer.sv
// IO command sequencer.
// Host commands are queued in a FIFO and issued one at a time to the IO unit.
// The command fields are held stable while the unit is busy.
// Read results are returned through a one-entry valid/ready response buffer.
module io_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned INSTRUCTION_SIZE = 3,
    parameter int unsigned SIZE_WORD        = 5,
    parameter int unsigned AUXILIAR_SIZE    = 44,
    parameter int unsigned IO_OUTPUT_SIZE   = 8,
    localparam int unsigned LvlW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    io_cmd_sequencer_if.slave   bus,
    input  logic                abort_i,
    output logic [LvlW-1:0]     fifo_level_o,
    output logic                seq_idle_o,
    output logic                err_o
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = INSTRUCTION_SIZE + SIZE_WORD + AUXILIAR_SIZE;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0]           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]             level_q, level_d;

    logic [INSTRUCTION_SIZE-1:0] io_instr_q;
    logic [SIZE_WORD-1:0]        io_reg_q;
    logic [AUXILIAR_SIZE-1:0]    io_aux_q;

    logic                        rsp_valid_q;
    logic [IO_OUTPUT_SIZE-1:0]   rsp_data_q;
    logic [SIZE_WORD-1:0]        rsp_reg_q;
    logic                        err_q;

    logic                        cmd_ready;
    logic                        fifo_empty;
    logic                        push, pop;
    logic [EntryW-1:0]           head;
    logic                        head_is_read;
    logic                        issue_ok;
    logic                        io_valid;
    logic                        load_rsp;
    logic                        set_err;
    logic [IO_OUTPUT_SIZE-1:0]   rsp_data_new;

    function automatic logic is_read(input logic [INSTRUCTION_SIZE-1:0] op);
        return (op == INSTRUCTION_SIZE'(4)) || (op == INSTRUCTION_SIZE'(5)) ||
               (op == INSTRUCTION_SIZE'(6));
    endfunction

    assign fifo_empty   = (level_q == '0);
    assign cmd_ready    = (level_q != LvlW'(FIFO_DEPTH));
    // A push in the abort cycle is discarded along with the rest of the queue.
    assign push         = bus.cmd_valid && cmd_ready && !abort_i;
    assign head         = mem_q[rd_ptr_q];
    assign head_is_read = is_read(head[EntryW-1 -: INSTRUCTION_SIZE]);
    // The response buffer is never overwritten, so a read may only issue once it is empty.
    assign issue_ok     = !fifo_empty && (!head_is_read || !rsp_valid_q);

    // Opcode 110 returns the full word; 100/101 return a single pin bit.
    assign rsp_data_new = (io_instr_q == INSTRUCTION_SIZE'(6)) ? bus.io_result
                                                               : IO_OUTPUT_SIZE'(bus.io_result[0]);

    // FIFO occupancy next-state
    always_comb begin
        level_d = level_q;
        if (abort_i) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (abort_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_instr, bus.cmd_reg, bus.cmd_aux};
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (issue_ok) state_d = StIssue;
            StIssue:    state_d = StWaitAck;
            StWaitAck:  state_d = bus.io_busy ? StWaitDone : StIdle;
            StWaitDone: if (!bus.io_busy) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        io_valid = 1'b0;
        pop      = 1'b0;
        load_rsp = 1'b0;
        set_err  = 1'b0;
        unique case (state_q)
            StIdle:     pop = issue_ok;
            StIssue:    io_valid = 1'b1;
            // The unit never acknowledged: drop the command and flag it.
            StWaitAck:  set_err = !bus.io_busy;
            StWaitDone: begin
                if (!bus.io_busy && is_read(io_instr_q)) begin
                    load_rsp = 1'b1;
                    set_err  = !bus.io_valid_io;
                end
            end
            default: ;
        endcase
    end

    // Issued command fields, response buffer and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_instr_q  <= '0;
            io_reg_q    <= '0;
            io_aux_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_reg_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if (pop) begin
                {io_instr_q, io_reg_q, io_aux_q} <= head;
            end
            if (load_rsp) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_new;
                rsp_reg_q   <= io_reg_q;
            end else if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            err_q <= (err_q && !abort_i) || set_err;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.io_instr  = io_instr_q;
    assign bus.io_reg    = io_reg_q;
    assign bus.io_aux    = io_aux_q;
    assign bus.io_valid  = io_valid;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_reg   = rsp_reg_q;

    assign fifo_level_o  = level_q;
    assign seq_idle_o    = fifo_empty && (state_q == StIdle);
    assign err_o         = err_q;
endmodule

// File: tb/tb_io_cmd_sequencer.sv
// Scoreboard bench for io_cmd_sequencer.
// Commands are queued when the host pushes them. Expected responses are queued at issue
// time, using the result the IO-unit model will return. A negedge monitor compares both.
module tb_io_cmd_sequencer;
    localparam int unsigned Depth = 4;
    localparam int unsigned LW    = 3;

    typedef struct packed {
        logic [2:0]  instr;
        logic [4:0]  rg;
        logic [43:0] aux;
    } cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] rg;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          seq_idle;
    logic          err;

    io_cmd_sequencer_if #(
        .INSTRUCTION_SIZE(3), .SIZE_WORD(5), .AUXILIAR_SIZE(44), .IO_OUTPUT_SIZE(8)
    ) bus ();

    io_cmd_sequencer #(
        .FIFO_DEPTH(Depth), .INSTRUCTION_SIZE(3), .SIZE_WORD(5), .AUXILIAR_SIZE(44),
        .IO_OUTPUT_SIZE(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .abort_i     (abort),
        .fifo_level_o(fifo_level),
        .seq_idle_o  (seq_idle),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    cmd_t exp_issue_q[$];
    rsp_t exp_rsp_q[$];
    int   exp_rise_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // IO unit model controls
    bit         model_start = 1'b0;
    int         model_d = 0;
    logic [7:0] model_res = 8'h00;
    int         model_cnt = 0;
    bit         never_busy = 1'b0;
    bit         rnd_result = 1'b0;
    logic [7:0] fixed_result = 8'h00;
    bit         rdy_rand = 1'b0;
    bit         rdy_fixed = 1'b1;

    // Monitor state
    int         cyc = 0;
    int         issue_count = 0;
    int         rsp_count = 0;
    int         last_issue = -100;
    cmd_t       cur;
    cmd_t       mon_c;
    bit         cur_valid = 1'b0;
    bit         rsp_prev = 1'b0;
    logic [7:0] mon_res;
    rsp_t       mon_r;
    int         mon_rise;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit op_is_read(input logic [2:0] op);
        return op inside {3'b100, 3'b101, 3'b110};
    endfunction

    function automatic int op_delay(input cmd_t c);
        return (c.instr inside {3'b000, 3'b010, 3'b100, 3'b101}) ? int'(c.aux) : 0;
    endfunction

    function automatic rsp_t predict_rsp(input cmd_t c, input logic [7:0] res);
        rsp_t r;
        r.data = (c.instr == 3'b110) ? res : {7'b0, res[0]};
        r.rg   = c.rg;
        return r;
    endfunction

    // IO unit: busy for D+1 cycles starting the cycle after the issue strobe, then ack
    initial begin
        bus.io_busy     = 1'b0;
        bus.io_valid_io = 1'b0;
        bus.io_result   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.io_busy     = 1'b0;
                bus.io_valid_io = 1'b0;
                model_start     = 1'b0;
                model_cnt       = 0;
            end else begin
                bus.io_valid_io = 1'b0;
                if (model_start) begin
                    model_start   = 1'b0;
                    bus.io_busy   = 1'b1;
                    bus.io_result = model_res;
                    model_cnt     = model_d + 1;
                end else if (bus.io_busy) begin
                    model_cnt--;
                    if (model_cnt == 0) begin
                        bus.io_busy     = 1'b0;
                        bus.io_valid_io = 1'b1;
                    end
                end
            end
        end
    end

    // Response consumer
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_fixed;
        end
    end

    // Monitor: issue order/content/spacing, field stability, response timing and content
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rsp_prev   = 1'b0;
            cur_valid  = 1'b0;
            last_issue = -100;
        end else begin
            if (bus.io_valid) begin
                issue_count++;
                if (exp_issue_q.size() == 0) begin
                    check("unexpected_issue", 64'(bus.io_instr), 64'hDEAD);
                end else begin
                    mon_c = exp_issue_q.pop_front();
                    check("issue_instr", 64'(bus.io_instr), 64'(mon_c.instr));
                    check("issue_reg", 64'(bus.io_reg), 64'(mon_c.rg));
                    check("issue_aux", 64'(bus.io_aux), 64'(mon_c.aux));
                    if (last_issue >= 0)
                        check("issue_gap_ge4", 64'((cyc - last_issue) >= 4), 64'(1));
                    last_issue = cyc;
                    cur        = mon_c;
                    cur_valid  = 1'b1;
                    if (!never_busy) begin
                        mon_res     = rnd_result ? 8'($urandom_range(0, 255)) : fixed_result;
                        model_d     = op_delay(mon_c);
                        model_res   = mon_res;
                        model_start = 1'b1;
                        if (op_is_read(mon_c.instr)) begin
                            exp_rsp_q.push_back(predict_rsp(mon_c, mon_res));
                            exp_rise_q.push_back(cyc + 3 + model_d);
                        end
                    end
                end
            end
            if (bus.io_busy && cur_valid)
                check("io_fields_stable", 64'({bus.io_instr, bus.io_reg, bus.io_aux}), 64'(cur));
            if (bus.rsp_valid && !rsp_prev) begin
                if (exp_rise_q.size() == 0) begin
                    check("unexpected_rsp", 64'(bus.rsp_data), 64'hDEAD);
                end else begin
                    mon_rise = exp_rise_q.pop_front();
                    check("rsp_latency", 64'(cyc), 64'(mon_rise));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp_xfer", 64'(bus.rsp_data), 64'hDEAD);
                end else begin
                    mon_r = exp_rsp_q.pop_front();
                    check("rsp_data", 64'(bus.rsp_data), 64'(mon_r.data));
                    check("rsp_reg", 64'(bus.rsp_reg), 64'(mon_r.rg));
                end
            end
            rsp_prev = bus.rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rg, input logic [43:0] aux);
        int w = 0;
        while (!bus.cmd_ready && w < 500) begin
            tick();
            w++;
        end
        if (!bus.cmd_ready) begin
            check("send_timeout", 64'(bus.cmd_ready), 64'(1));
        end else begin
            bus.cmd_valid = 1'b1;
            bus.cmd_instr = op;
            bus.cmd_reg   = rg;
            bus.cmd_aux   = aux;
            exp_issue_q.push_back(cmd_t'{instr: op, rg: rg, aux: aux});
            tick();
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_issues(input int n);
        int w = 0;
        while (issue_count < n && w < 500) begin
            tick();
            w++;
        end
        if (issue_count < n) check("issue_timeout", 64'(issue_count), 64'(n));
    endtask

    task automatic drain();
        int w = 0;
        bit done = 1'b0;
        while (!done && w < 3000) begin
            tick();
            w++;
            done = (exp_issue_q.size() == 0) && (exp_rsp_q.size() == 0) && seq_idle &&
                   !bus.io_busy && !bus.rsp_valid && !model_start;
        end
        check("drain_complete", 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [2:0]  op;
        logic [43:0] aux;

        bus.cmd_valid = 1'b0;
        bus.cmd_instr = '0;
        bus.cmd_reg   = '0;
        bus.cmd_aux   = '0;
        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_seq_idle", 64'(seq_idle), 64'(1));
        check("rst_io_valid", 64'(bus.io_valid), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_io_fields", 64'({bus.io_instr, bus.io_reg, bus.io_aux}), 64'(0));
        check("rst_fifo_level", 64'(fifo_level), 64'(0));
        check("rst_rsp_fields", 64'({bus.rsp_data, bus.rsp_reg}), 64'(0));

        // Zero-delay full-word read
        fixed_result = 8'hA5;
        send(3'b110, 5'd3, 44'h0_0000_00F0_3C5);
        drain();

        // Delayed single-pin read, aux held through a 6-cycle busy
        fixed_result = 8'hFF;
        send(3'b100, 5'd7, 44'd5);
        drain();

        // Fill the FIFO behind a long write; the fifth push is refused
        base = issue_count;
        send(3'b000, 5'd1, 44'd30);
        wait_issues(base + 1);
        for (int i = 0; i < 4; i++) send(3'b011, 5'(i + 2), 44'({$urandom(), $urandom()}));
        check("full_level", 64'(fifo_level), 64'(exp_issue_q.size()));
        check("full_cmd_ready", 64'(bus.cmd_ready), 64'(exp_issue_q.size() < Depth));
        check("full_not_idle", 64'(seq_idle), 64'(0));
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = 3'b011;
        bus.cmd_reg   = 5'd31;
        bus.cmd_aux   = 44'h123;
        tick();
        bus.cmd_valid = 1'b0;
        check("full_refused_level", 64'(fifo_level), 64'(exp_issue_q.size()));
        drain();

        // Second read is held back while the first response is unconsumed
        rdy_fixed    = 1'b0;
        fixed_result = 8'h5B;
        tick();
        tick();
        base = issue_count;
        send(3'b110, 5'd1, 44'hF0);
        send(3'b101, 5'd2, 44'd0);
        repeat (20) tick();
        check("gated_issue_count", 64'(issue_count), 64'(base + 1));
        check("gated_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("gated_fifo_level", 64'(fifo_level), 64'(exp_issue_q.size()));
        rdy_fixed = 1'b1;
        drain();
        check("gated_second_issued", 64'(issue_count), 64'(base + 2));

        // IO unit never acknowledges -> sticky error, FSM back to idle
        never_busy = 1'b1;
        base = issue_count;
        send(3'b011, 5'd9, 44'd123);
        wait_issues(base + 1);
        check("noack_err_before", 64'(err), 64'(0));
        tick();
        check("noack_err_set", 64'(err), 64'(1));
        check("noack_idle", 64'(seq_idle), 64'(1));
        never_busy = 1'b0;

        // Abort with three queued and a read in flight
        fixed_result = 8'h3D;
        base = issue_count;
        send(3'b100, 5'd12, 44'd20);
        wait_issues(base + 1);
        for (int i = 0; i < 3; i++) send(3'b001, 5'(i + 20), 44'(i * 7 + 1));
        check("pre_abort_level", 64'(fifo_level), 64'(exp_issue_q.size()));
        check("pre_abort_err", 64'(err), 64'(1));
        abort = 1'b1;
        exp_issue_q.delete();
        tick();
        abort = 1'b0;
        check("abort_err", 64'(err), 64'(0));
        check("abort_level", 64'(fifo_level), 64'(0));
        check("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        base = rsp_count;
        drain();
        check("abort_inflight_rsp", 64'(rsp_count), 64'(base + 1));

        // Randomized traffic with random results and back-pressure
        rnd_result = 1'b1;
        rdy_rand   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            aux = (op inside {3'b000, 3'b010, 3'b100, 3'b101}) ? 44'($urandom_range(0, 6))
                                                                : 44'({$urandom(), $urandom()});
            send(op, 5'($urandom_range(0, 31)), aux);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) tick();
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        drain();
        check("random_no_err", 64'(err), 64'(0));

        // Reset in the middle of a command
        rnd_result   = 1'b0;
        fixed_result = 8'h81;
        base = issue_count;
        send(3'b000, 5'd4, 44'd15);
        send(3'b110, 5'd5, 44'd0);
        wait_issues(base + 1);
        rst = 1'b1;
        exp_issue_q.delete();
        exp_rsp_q.delete();
        exp_rise_q.delete();
        #1;
        check("midrst_io_valid", 64'(bus.io_valid), 64'(0));
        check("midrst_io_fields", 64'({bus.io_instr, bus.io_reg, bus.io_aux}), 64'(0));
        check("midrst_level", 64'(fifo_level), 64'(0));
        check("midrst_seq_idle", 64'(seq_idle), 64'(1));
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(3'b110, 5'd6, 44'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
